// File: rtl/rv32i_wb_skid_stage_pkg.sv
// Shared types and helpers for the MEM->WB skid stage.
// State encoding equals the number of valid entries, so occupancy is the state itself.
package rv32i_wb_skid_stage_pkg;

    typedef enum logic [1:0] {
        WbStEmpty = 2'b00,
        WbStBusy  = 2'b01,
        WbStFull  = 2'b10
    } wb_state_e;

    localparam logic RstActiveLow = 1'b0;
    localparam logic WriteDisable = 1'b0;

    // Write enable as stored in an entry: writes to x0 are optionally dropped here.
    function automatic logic gate_we(logic we, logic addr_is_zero, logic suppress_x0);
        return we & ~(suppress_x0 & addr_is_zero);
    endfunction

endpackage

// File: rtl/rv32i_wb_skid_stage.sv
// MEM->WB pipeline stage: output register plus one skid entry, registered in_ready,
// synchronous flush and optional suppression of x0 writes.
module rv32i_wb_skid_stage
    import rv32i_wb_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter bit          SUPPRESS_X0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [1:0]        occupancy
);

    wb_state_e         state_q, state_d;
    logic              out_we_q, out_we_d;
    logic [ADDR_W-1:0] out_waddr_q, out_waddr_d;
    logic [DATA_W-1:0] out_wdata_q, out_wdata_d;
    logic              skid_we_q, skid_we_d;
    logic [ADDR_W-1:0] skid_waddr_q, skid_waddr_d;
    logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;

    logic accept;
    logic consume;
    logic beat_we;

    assign in_ready  = (state_q != WbStFull);
    assign out_valid = (state_q != WbStEmpty);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign beat_we   = gate_we(in_we, in_waddr == '0, SUPPRESS_X0);

    assign reg_we    = out_valid & out_we_q;
    assign reg_waddr = out_waddr_q;
    assign reg_wdata = out_wdata_q;
    assign occupancy = state_q;

    always_comb begin
        state_d      = state_q;
        out_we_d     = out_we_q;
        out_waddr_d  = out_waddr_q;
        out_wdata_d  = out_wdata_q;
        skid_we_d    = skid_we_q;
        skid_waddr_d = skid_waddr_q;
        skid_wdata_d = skid_wdata_q;

        // Flush only drops valid bits; stored payloads stay put.
        if (flush) begin
            state_d = WbStEmpty;
        end else begin
            unique case (state_q)
                WbStEmpty: begin
                    if (accept) begin
                        out_we_d    = beat_we;
                        out_waddr_d = in_waddr;
                        out_wdata_d = in_wdata;
                        state_d     = WbStBusy;
                    end
                end
                WbStBusy: begin
                    if (accept && consume) begin
                        out_we_d    = beat_we;
                        out_waddr_d = in_waddr;
                        out_wdata_d = in_wdata;
                    end else if (accept) begin
                        skid_we_d    = beat_we;
                        skid_waddr_d = in_waddr;
                        skid_wdata_d = in_wdata;
                        state_d      = WbStFull;
                    end else if (consume) begin
                        state_d = WbStEmpty;
                    end
                end
                WbStFull: begin
                    if (consume) begin
                        out_we_d    = skid_we_q;
                        out_waddr_d = skid_waddr_q;
                        out_wdata_d = skid_wdata_q;
                        state_d     = WbStBusy;
                    end
                end
                default: state_d = WbStEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActiveLow) begin
            state_q      <= WbStEmpty;
            out_we_q     <= WriteDisable;
            out_waddr_q  <= '0;
            out_wdata_q  <= '0;
            skid_we_q    <= WriteDisable;
            skid_waddr_q <= '0;
            skid_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            out_we_q     <= out_we_d;
            out_waddr_q  <= out_waddr_d;
            out_wdata_q  <= out_wdata_d;
            skid_we_q    <= skid_we_d;
            skid_waddr_q <= skid_waddr_d;
            skid_wdata_q <= skid_wdata_d;
        end
    end

endmodule

// File: doc/rv32i_wb_skid_stage.md
Name: rv32i_wb_skid_stage

Overview:
Parametrised MEM→WB pipeline stage for the RV32I core with a valid/ready handshake on both sides.
A two-entry skid buffer (output register plus one skid register) lets the MEM stage keep issuing for one cycle after WB back-pressures, without a combinational ready path.
The block adds a synchronous flush and optional suppression of writes to register x0.
It sits between the MEM stage and the register-file write port.

Parameters:
DATA_W, 32, width of write-back data
ADDR_W, 5, width of destination register address
SUPPRESS_X0, 1, when 1 a beat with waddr==0 is stored with we=0

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
flush  in  1  synchronous pipeline flush (branch/trap), active-high
in_valid  in  1  MEM stage presents a beat
in_ready  out  1  stage can accept a beat this cycle
in_we  in  1  beat writes the register file
in_waddr  in  ADDR_W  destination register
in_wdata  in  DATA_W  write-back data
out_valid  out  1  output register holds a valid beat
out_ready  in  1  WB/register file consumes the beat this cycle
reg_we  out  1  out_valid AND stored we
reg_waddr  out  ADDR_W  stored destination register of the output beat
reg_wdata  out  DATA_W  stored data of the output beat
occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY; out_valid=0, reg_we=0, reg_waddr=0, reg_wdata=0, skid entry cleared, occupancy=0. in_ready=1 but inputs are ignored while rst=0. The first accept is possible on the first rising edge after rst deasserts.
- in_ready = (state != FULL); it is derived from registers only, with no path from out_ready.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- Stored we = in_we & ~(SUPPRESS_X0 & (in_waddr==0)). waddr and wdata are stored unmodified.
- States and transitions (evaluated at posedge, flush=0):
  - EMPTY, occupancy 0: accept → BUSY, beat loaded into the output register; otherwise stay.
  - BUSY, occupancy 1:
    - accept & consume → BUSY, new beat loaded into the output register.
    - accept & ~consume → FULL, new beat loaded into skid.
    - ~accept & consume → EMPTY.
    - Otherwise hold; the output register is stable.
  - FULL, occupancy 2, in_ready=0: consume → BUSY, skid moved to the output register; otherwise hold both.
- Latency: an accepted beat appears on out_valid/reg_* the cycle after acceptance when the stage is EMPTY or is being drained. Throughput is 1 beat per cycle when out_ready stays high.
- Ordering: strictly FIFO; a beat is never lost or duplicated.
- Output stability: while out_valid=1 and out_ready=0, reg_we/reg_waddr/reg_wdata do not change.
- Flush (synchronous, highest priority over accept and consume):
  - Next state is EMPTY; both valid bits are cleared; occupancy=0.
  - Any beat offered in the flush cycle is dropped.
  - reg_waddr/reg_wdata keep their last values; reg_we=0 because out_valid=0.
  - A consume in the flush cycle still counts downstream, since the register file samples it that edge.
- reg_waddr/reg_wdata are only meaningful when out_valid=1; the bench checks them only then.
- Reset mid-operation: all entries are discarded immediately, regardless of handshake state.
- When SUPPRESS_X0=0, a write to x0 passes through with reg_we=1; the register file is responsible for ignoring it.

Decomposition:
- DEFINES.v gains:
  - `RstActiveLow 1'b0` for the new reset polarity.
  - 2-bit state encodings `WbStEmpty 2'b00`, `WbStBusy 2'b01`, `WbStFull 2'b10`.
- Existing `ZeroWord`, `WriteDisable` and `regAddr0` macros are reused for reset values.
- Single module, no sub-module. The skid and output entries are two instances of the same register group, written inline.

Test Plan:
- Streaming: out_ready=1; beats (we=1,x5,0x11111111), (we=1,x6,0x22222222), (we=1,x7,0x33333333) on 3 consecutive cycles → same triple on reg_* on cycles 1,2,3 after input; occupancy stays 1; in_ready stays 1.
- Back-pressure: out_ready=0 from cycle 1, beats x5 then x6 → occupancy 2, in_ready=0, reg_waddr=5 held. Raising out_ready drains x5 then x6 in order; in_ready returns to 1 one cycle after the first consume.
- x0 suppression: SUPPRESS_X0=1, beat (we=1,x0,0xDEADBEEF) → out_valid=1, reg_we=0. With SUPPRESS_X0=0, the same beat → reg_we=1.
- Flush while FULL with in_valid=1 → next cycle occupancy=0, out_valid=0, reg_we=0, in_ready=1; the flushed beats and the offered beat never appear.
- Async reset: rst pulled low mid-cycle in state FULL → outputs are zero before the next clock edge. After release, beat (x9,0x00000009) passes with 1-cycle latency.
- Random soak: random in_valid/out_ready/flush over 10k cycles against a reference queue model → every consumed beat matches FIFO order, nothing is consumed while out_valid=0, and occupancy never exceeds 2.
